sd_cmd_tx: RTL and testbench

- SD command-line transmitter; sits directly downstream of the UART block.
- Consumes the UART's 6-bit command index and enable pulse, plus a 32-bit argument.
- Builds the 48-bit SD command frame, including CRC7, and shifts it MSB-first onto the SD CMD pin.
- Generates SD_CLK from the 50 MHz system clock.

---
 rtl/sd_cmd_tx.sv | 138 +++++++++++++
 tb/tb_sd_cmd_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_tx.sv
// SD command-line transmitter: latches index/argument, computes CRC7 serially,
// then shifts the 48-bit frame MSB-first onto CMD under a divided SD_CLK.
module sd_cmd_tx #(
    parameter int unsigned CLK_DIV   = 126,
    parameter int unsigned TAIL_CLKS = 8
) (
    input  logic        ex_clk,
    input  logic        reset,
    input  logic        cmd_en,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        sd_clk,
    output logic        sd_cmd,
    output logic        busy,
    output logic        done
);
    localparam int unsigned FRAME_W = 40;
    localparam int unsigned CMD_W   = 48;
    localparam int unsigned REST_W  = CMD_W - 1;
    localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_MAX = (TAIL_CLKS > CMD_W) ? TAIL_CLKS : CMD_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CRC   = 2'd1,
        S_SHIFT = 2'd2,
        S_TAIL  = 2'd3
    } state_t;

    state_t              state;
    logic [FRAME_W-1:0]  frame;
    logic [6:0]          crc;
    logic [REST_W-1:0]   rest;
    logic [DIV_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    bit_cnt;

    logic [6:0]          crc_nxt;
    logic [FRAME_W-1:0]  frame_rot;
    logic [DIV_W-1:0]    div_nxt;
    logic                div_wrap;
    logic                crc_fb;

    // The frame register rotates during CRC so it is back in order after 40 steps.
    always_comb begin
        crc_fb    = frame[FRAME_W-1] ^ crc[6];
        crc_nxt   = {crc[5:3], crc[2] ^ crc_fb, crc[1:0], crc_fb};
        frame_rot = {frame[FRAME_W-2:0], frame[FRAME_W-1]};
        div_nxt   = div_cnt + DIV_W'(1);
        div_wrap  = (div_cnt == DIV_W'(CLK_DIV - 1));
    end

    always_ff @(posedge ex_clk) begin
        if (reset) begin
            state   <= S_IDLE;
            frame   <= '0;
            crc     <= '0;
            rest    <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sd_clk  <= 1'b0;
            sd_cmd  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    sd_clk <= 1'b0;
                    sd_cmd <= 1'b1;
                    if (cmd_en) begin
                        frame   <= {2'b01, cmd_index, cmd_arg};
                        crc     <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= S_CRC;
                    end
                end

                S_CRC: begin
                    frame <= frame_rot;
                    crc   <= crc_nxt;
                    if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                        // Start bit goes out now; the rest queues behind it.
                        sd_cmd  <= frame_rot[FRAME_W-1];
                        rest    <= {frame_rot[FRAME_W-2:0], crc_nxt, 1'b1};
                        div_cnt <= '0;
                        sd_clk  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= S_SHIFT;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                S_SHIFT: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        sd_clk  <= 1'b0;
                        if (bit_cnt == CNT_W'(CMD_W - 1)) begin
                            sd_cmd  <= 1'b1;
                            bit_cnt <= '0;
                            state   <= S_TAIL;
                        end else begin
                            sd_cmd  <= rest[REST_W-1];
                            rest    <= {rest[REST_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else begin
                        div_cnt <= div_nxt;
                        sd_clk  <= (div_nxt >= DIV_W'(CLK_DIV / 2));
                    end
                end

                S_TAIL: begin
                    sd_cmd <= 1'b1;
                    if (div_wrap) begin
                        div_cnt <= '0;
                        sd_clk  <= 1'b0;
                        if (bit_cnt == CNT_W'(TAIL_CLKS - 1)) begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else begin
                        div_cnt <= div_nxt;
                        sd_clk  <= (div_nxt >= DIV_W'(CLK_DIV / 2));
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_tx.sv
// Scoreboard bench for sd_cmd_tx: frames are captured on SD_CLK rising edges
// and compared against expected frames queued when each command is issued.
module tb_sd_cmd_tx;
    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned TAIL_CLKS = 8;
    localparam int unsigned BUSY_LEN  = 40 + (48 + TAIL_CLKS) * CLK_DIV;

    logic        ex_clk    = 1'b0;
    logic        reset     = 1'b1;
    logic        cmd_en    = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg   = '0;
    logic        sd_clk, sd_cmd, busy, done;

    int          total = 0;
    int          bad   = 0;
    logic [47:0] sb[$];
    int          accepted = 0;
    int          done_cnt = 0;
    int          busy_len = 0;
    int          edges    = 0;
    int          clk_err  = 0;
    int          tail_err = 0;
    logic [47:0] cap      = '0;
    logic        prev_clk = 1'b0;
    logic        prev_cmd = 1'b1;

    sd_cmd_tx #(.CLK_DIV(CLK_DIV), .TAIL_CLKS(TAIL_CLKS)) dut (
        .ex_clk    (ex_clk),
        .reset     (reset),
        .cmd_en    (cmd_en),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .sd_clk    (sd_clk),
        .sd_cmd    (sd_cmd),
        .busy      (busy),
        .done      (done)
    );

    always #10 ex_clk = ~ex_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // CRC7 by polynomial long division of msg*x^7 by x^7+x^3+1.
    function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        logic [46:0] v;
        m = {2'b01, idx, arg};
        v = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        return {m, v[6:0], 1'b1};
    endfunction

    task automatic mon_clear();
        busy_len = 0;
        edges    = 0;
        clk_err  = 0;
        tail_err = 0;
        cap      = '0;
    endtask

    // Monitor: checks clock shape against an independent phase model and captures bits.
    always @(negedge ex_clk) begin
        if (reset) begin
            mon_clear();
            prev_clk = 1'b0;
            prev_cmd = 1'b1;
        end else begin
            if (busy) begin
                busy_len++;
                if (busy_len <= 40) begin
                    if (sd_clk !== 1'b0 || sd_cmd !== 1'b1) clk_err++;
                end else begin
                    int ph;
                    ph = (busy_len - 41) % CLK_DIV;
                    if (sd_clk !== (ph >= CLK_DIV / 2)) clk_err++;
                    if (sd_cmd !== prev_cmd && ph != 0) clk_err++;
                end
                if (sd_clk && !prev_clk) begin
                    edges++;
                    if (edges <= 48) cap = {cap[46:0], sd_cmd};
                    else if (sd_cmd !== 1'b1) tail_err++;
                end
            end
            if (done) begin
                done_cnt++;
                chk("sb_pending", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) chk("frame", 64'(cap), 64'(sb.pop_front()));
                chk("busy_len", 64'(busy_len), 64'(BUSY_LEN));
                chk("sdclk_edges", 64'(edges), 64'(48 + TAIL_CLKS));
                chk("tail_high_err", 64'(tail_err), 64'd0);
                chk("clk_shape_err", 64'(clk_err), 64'd0);
                chk("busy_in_done", 64'(busy), 64'd0);
                chk("cmd_in_done", 64'(sd_cmd), 64'd1);
                mon_clear();
            end
            prev_clk = sd_clk;
            prev_cmd = sd_cmd;
        end
    end

    task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] exp);
        cmd_index = idx;
        cmd_arg   = arg;
        cmd_en    = 1'b1;
        sb.push_back(exp);
        accepted++;
        @(posedge ex_clk); #1;
        cmd_en = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 1000) begin
            @(posedge ex_clk); #1;
            n++;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge ex_clk); #1;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sdclk"}, 64'(sd_clk), 64'd0);
        chk({tag, "_sdcmd"}, 64'(sd_cmd), 64'd1);
        chk({tag, "_busy"},  64'(busy),   64'd0);
        chk({tag, "_done"},  64'(done),   64'd0);
    endtask

    initial begin
        logic [31:0] arg;
        logic [5:0]  idx;
        int          n;

        gap(3);
        chk_idle("reset");
        reset = 1'b0;
        gap(1);

        send(6'd0, 32'h0, 48'h40_00000000_95);
        chk("busy_rise", 64'(busy), 64'd1);
        wait_done();
        gap(1);
        chk("cmd_idle_after", 64'(sd_cmd), 64'd1);
        chk("done_one_cycle", 64'(done), 64'd0);

        gap(3);
        send(6'd8, 32'h0000_01AA, 48'h48_000001AA_87);
        wait_done();
        gap(3);
        send(6'd17, 32'h0, 48'h51_00000000_55);
        wait_done();

        // Re-pulse mid-SHIFT and change inputs after accept: frame must not change.
        gap(3);
        arg = $urandom;
        send(6'd24, arg, model_frame(6'd24, arg));
        cmd_index = 6'd5;
        cmd_arg   = ~arg;
        gap(100);
        cmd_en = 1'b1;
        gap(1);
        cmd_en = 1'b0;
        wait_done();
        gap(20);
        chk("no_restart", 64'(busy), 64'd0);
        chk("single_done", 64'(done_cnt), 64'(accepted));

        // Reset during bit 20 of SHIFT.
        arg = $urandom;
        send(6'd17, arg, model_frame(6'd17, arg));
        n = 0;
        while (edges < 20 && n < 2000) begin
            @(posedge ex_clk); #1;
            n++;
        end
        chk("reach_bit20", 64'(edges >= 20), 64'd1);
        gap(CLK_DIV);
        reset = 1'b1;
        void'(sb.pop_back());
        accepted--;
        gap(1);
        chk_idle("abort");
        reset = 1'b0;
        gap(2);
        send(6'd0, 32'h0, 48'h40_00000000_95);
        wait_done();

        // cmd_en in the done cycle is accepted.
        gap(3);
        send(6'd55, 32'h0, model_frame(6'd55, 32'h0));
        wait_done();
        send(6'd41, 32'h40FF_8000, model_frame(6'd41, 32'h40FF_8000));
        chk("busy_after_done_accept", 64'(busy), 64'd1);
        wait_done();

        // Reset wins over cmd_en.
        gap(3);
        reset     = 1'b1;
        cmd_en    = 1'b1;
        cmd_index = 6'd2;
        gap(1);
        chk("rst_cmd_busy", 64'(busy), 64'd0);
        cmd_en = 1'b0;
        reset  = 1'b0;
        gap(5);
        chk("rst_cmd_still_idle", 64'(busy), 64'd0);

        for (int k = 0; k < 3; k++) begin
            idx = 6'($urandom_range(0, 63));
            arg = $urandom;
            send(idx, arg, model_frame(idx, arg));
            wait_done();
            gap(2 + k);
        end

        gap(10);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("done_total", 64'(done_cnt), 64'(accepted));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
